// File: rtl/store_monitor_if.sv
// Bus between the core's data-memory write port, the monitor, and the log drain side.
// The core/drain side uses master; the monitor uses slave.
interface store_monitor_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          MemWrite;
  logic [31:0]   DataAdr;
  logic [31:0]   WriteData;
  logic          log_valid;
  logic          log_ready;
  logic [31:0]   log_adr;
  logic [31:0]   log_data;
  logic [CW-1:0] log_count;
  logic          overflow;
  logic [15:0]   drop_count;
  logic [15:0]   store_count;
  logic          done;
  logic          pass;
  logic          fail;

  modport master (
    output MemWrite, DataAdr, WriteData, log_ready,
    input  log_valid, log_adr, log_data, log_count, overflow,
           drop_count, store_count, done, pass, fail
  );

  modport slave (
    input  MemWrite, DataAdr, WriteData, log_ready,
    output log_valid, log_adr, log_data, log_count, overflow,
           drop_count, store_count, done, pass, fail
  );
endinterface

// File: rtl/store_monitor.sv
// Store monitor: snoops the core's data-memory writes, logs them into a
// first-word-fall-through FIFO, and latches a sticky pass/fail verdict.
module store_monitor #(
  parameter int          DEPTH       = 8,
  parameter logic [31:0] PASS_ADR    = 32'd100,
  parameter logic [31:0] PASS_DATA   = 32'd25,
  parameter logic [31:0] SCRATCH_ADR = 32'd96
) (
  input  logic           clk,
  input  logic           reset,
  store_monitor_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } state_t;

  state_t        state_q, state_d;
  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q;
  logic          ovf_q, pass_q, fail_q;
  logic [15:0]   drop_q, stores_q;
  logic          push_req, full, pop, push, drop, valid;

  // Store qualification and FIFO handshake; a pop frees the slot for a same-cycle push.
  always_comb begin
    push_req = bus.MemWrite && (state_q == ST_RUN);
    full     = (count_q == FULL);
    valid    = (count_q != '0);
    pop      = valid && bus.log_ready;
    push     = push_req && (!full || pop);
    drop     = push_req && full && !pop;
  end

  // Verdict next-state: only stores seen in RUN can decide, dropped ones included.
  always_comb begin
    state_d = state_q;
    if (push_req) begin
      if (bus.DataAdr == PASS_ADR && bus.WriteData == PASS_DATA)
        state_d = ST_PASS;
      else if (bus.DataAdr != SCRATCH_ADR)
        state_d = ST_FAIL;
    end
  end

  // State register plus registered verdict flags, visible the cycle after the deciding store.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pass_q  <= (state_d == ST_PASS);
      fail_q  <= (state_d == ST_FAIL);
    end
  end

  // FIFO storage; contents need no reset because the outputs are gated by valid.
  always_ff @(posedge clk) begin
    if (!reset && push)
      mem[wr_ptr] <= '{adr: bus.DataAdr, data: bus.WriteData};
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Saturating store/drop accounting and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      stores_q <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_req && stores_q != 16'hFFFF) stores_q <= stores_q + 16'd1;
      if (drop) begin
        ovf_q <= 1'b1;
        if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      end
    end
  end

  assign head            = mem[rd_ptr];
  assign bus.log_valid   = valid;
  assign bus.log_adr     = valid ? head.adr  : '0;
  assign bus.log_data    = valid ? head.data : '0;
  assign bus.log_count   = count_q;
  assign bus.overflow    = ovf_q;
  assign bus.drop_count  = drop_q;
  assign bus.store_count = stores_q;
  assign bus.pass        = pass_q;
  assign bus.fail        = fail_q;
  assign bus.done        = pass_q | fail_q;
endmodule

// File: tb/tb_store_monitor.sv
// Bench for store_monitor: table vectors, hand-written corner sequences and
// random traffic, all cross-checked against a queue-based reference model.
module tb_store_monitor;
  localparam int          DEPTH       = 8;
  localparam logic [31:0] PASS_ADR    = 32'd100;
  localparam logic [31:0] PASS_DATA   = 32'd25;
  localparam logic [31:0] SCRATCH_ADR = 32'd96;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  store_monitor_if #(.DEPTH(DEPTH)) bus ();

  store_monitor #(
    .DEPTH(DEPTH), .PASS_ADR(PASS_ADR), .PASS_DATA(PASS_DATA), .SCRATCH_ADR(SCRATCH_ADR)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of {adr,data}, counters and a verdict.
  localparam int V_RUN = 0, V_PASS = 1, V_FAIL = 2;
  logic [63:0] mq[$];
  int          m_sc = 0, m_dc = 0, m_v = V_RUN;
  logic        m_ov = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic mw, input logic [31:0] a,
                            input logic [31:0] d, input logic rdy);
    logic [63:0] tmp;
    if (r) begin
      mq.delete();
      m_sc = 0; m_dc = 0; m_ov = 1'b0; m_v = V_RUN;
      return;
    end
    if (mq.size() > 0 && rdy) tmp = mq.pop_front();
    if (mw && m_v == V_RUN) begin
      if (m_sc < 65535) m_sc++;
      if (mq.size() < DEPTH) mq.push_back({a, d});
      else begin
        m_ov = 1'b1;
        if (m_dc < 65535) m_dc++;
      end
      if (a == PASS_ADR && d == PASS_DATA) m_v = V_PASS;
      else if (a != SCRATCH_ADR)          m_v = V_FAIL;
    end
  endtask

  task automatic cmp_model();
    logic [63:0] h;
    logic        v;
    v = (mq.size() != 0);
    h = v ? mq[0] : 64'd0;
    chk("m_valid", bus.log_valid, v);
    chk("m_adr",   bus.log_adr,   h[63:32]);
    chk("m_data",  bus.log_data,  h[31:0]);
    chk("m_count", bus.log_count, mq.size());
    chk("m_ovf",   bus.overflow,  m_ov);
    chk("m_drop",  bus.drop_count, m_dc);
    chk("m_sc",    bus.store_count, m_sc);
    chk("m_pass",  bus.pass, m_v == V_PASS);
    chk("m_fail",  bus.fail, m_v == V_FAIL);
    chk("m_done",  bus.done, m_v != V_RUN);
  endtask

  // One clock: drive at negedge, advance the model at posedge, compare just after.
  task automatic step(input logic r, input logic mw, input logic [31:0] a,
                      input logic [31:0] d, input logic rdy);
    @(negedge clk);
    reset = r; bus.MemWrite = mw; bus.DataAdr = a; bus.WriteData = d; bus.log_ready = rdy;
    @(posedge clk);
    model_edge(r, mw, a, d, rdy);
    #1;
    cmp_model();
  endtask

  typedef struct {
    logic        r, mw;
    logic [31:0] a, d;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_adr, e_data;
    logic [3:0]  e_cnt;
    logic [15:0] e_sc;
    logic        e_pass, e_fail, e_done;
  } vec_t;

  vec_t tbl [9];

  initial begin
    bus.MemWrite = 1'b0; bus.DataAdr = '0; bus.WriteData = '0; bus.log_ready = 1'b0;

    //        r     mw    adr      data     rdy   valid adr      data     cnt   sc      pass  fail  done
    tbl[0] = '{1'b1, 1'b1, 32'd100, 32'd25, 1'b0, 1'b0, 32'd0,   32'd0,  4'd0, 16'd0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 32'd96,  32'd7,  1'b0, 1'b1, 32'd96,  32'd7,  4'd1, 16'd1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 32'd100, 32'd25, 1'b1, 1'b1, 32'd100, 32'd25, 4'd1, 16'd2, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 32'd80,  32'd1,  1'b0, 1'b1, 32'd100, 32'd25, 4'd1, 16'd2, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 32'd0,   32'd0,  1'b1, 1'b0, 32'd0,   32'd0,  4'd0, 16'd2, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 32'd0,   32'd0,  1'b0, 1'b0, 32'd0,   32'd0,  4'd0, 16'd0, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 32'd80,  32'd3,  1'b0, 1'b1, 32'd80,  32'd3,  4'd1, 16'd1, 1'b0, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 32'd100, 32'd25, 1'b0, 1'b1, 32'd80,  32'd3,  4'd1, 16'd1, 1'b0, 1'b1, 1'b1};
    tbl[8] = '{1'b1, 1'b1, 32'd96,  32'd5,  1'b0, 1'b0, 32'd0,   32'd0,  4'd0, 16'd0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 9; i++) begin
      step(tbl[i].r, tbl[i].mw, tbl[i].a, tbl[i].d, tbl[i].rdy);
      chk($sformatf("t%0d_valid", i), bus.log_valid,   tbl[i].e_valid);
      chk($sformatf("t%0d_adr", i),   bus.log_adr,     tbl[i].e_adr);
      chk($sformatf("t%0d_data", i),  bus.log_data,    tbl[i].e_data);
      chk($sformatf("t%0d_cnt", i),   bus.log_count,   tbl[i].e_cnt);
      chk($sformatf("t%0d_sc", i),    bus.store_count, tbl[i].e_sc);
      chk($sformatf("t%0d_pass", i),  bus.pass,        tbl[i].e_pass);
      chk($sformatf("t%0d_fail", i),  bus.fail,        tbl[i].e_fail);
      chk($sformatf("t%0d_done", i),  bus.done,        tbl[i].e_done);
    end

    // Overflow: ten scratch stores into an undrained 8-deep FIFO.
    step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 32'd96, 32'(i), 1'b0);
    chk("ovf_count", bus.log_count, 32'd8);
    chk("ovf_flag",  bus.overflow,  32'd1);
    chk("ovf_drop",  bus.drop_count, 32'd2);
    chk("ovf_head",  bus.log_data,  32'd0);

    // Full FIFO with simultaneous push and pop: push is accepted, no drop.
    step(1'b0, 1'b1, 32'd96, 32'd42, 1'b1);
    chk("fullpp_count", bus.log_count, 32'd8);
    chk("fullpp_drop",  bus.drop_count, 32'd2);

    // Drain: 1..7 then 42, then empty.
    for (int k = 0; k < 8; k++) begin
      chk("drain_head", bus.log_data, (k < 7) ? 32'(k + 1) : 32'd42);
      step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    end
    chk("drain_empty", bus.log_valid, 32'd0);

    // Reset mid-operation with a store on the reset cycle.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'd96, 32'(i + 20), 1'b0);
    chk("pre_rst_count", bus.log_count, 32'd3);
    step(1'b1, 1'b1, 32'd100, 32'd25, 1'b0);
    chk("rst_valid", bus.log_valid, 32'd0);
    chk("rst_count", bus.log_count, 32'd0);
    chk("rst_sc",    bus.store_count, 32'd0);
    chk("rst_done",  bus.done, 32'd0);
    chk("rst_pass",  bus.pass, 32'd0);
    chk("rst_ovf",   bus.overflow, 32'd0);

    // Random traffic, mostly scratch stores so the FIFO fills and drains.
    for (int n = 0; n < 600; n++) begin
      logic        r, mw, rdy;
      logic [31:0] a, d;
      int          sel;
      r   = ($urandom_range(0, 99) < 3);
      mw  = ($urandom_range(0, 99) < 60);
      rdy = ($urandom_range(0, 99) < 45);
      sel = $urandom_range(0, 99);
      if (sel < 80)      begin a = SCRATCH_ADR; d = $urandom; end
      else if (sel < 88) begin a = PASS_ADR;    d = PASS_DATA; end
      else if (sel < 93) begin a = PASS_ADR;    d = 32'($urandom_range(0, 30)); end
      else               begin a = $urandom;    d = $urandom; end
      step(r, mw, a, d, rdy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
